// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, fetch FSM states.
package y86_pkg;

    // Instruction codes (upper nibble of the first instruction byte)
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Register id meaning "no register"
    localparam logic [3:0] REG_NONE = 4'hF;

    // Pipeline status codes
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // Fetch controller states
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT0,
        S_WAIT1,
        S_WAIT2,
        S_OUT,
        S_HALTED
    } fetch_state_t;

endpackage

// File: rtl/y86_inst_len.sv
// Instruction-format lookup: length, presence of the register byte and of the
// constant word, and where the constant starts relative to the first byte.
module y86_inst_len
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] len,
    output logic       need_regids,
    output logic       need_valC,
    output logic [3:0] valC_offset,
    output logic       instr_valid
);

    // Classify the icode; unknown codes are treated as one-byte invalid instructions
    always_comb begin
        need_regids = 1'b0;
        need_valC   = 1'b0;
        instr_valid = 1'b1;
        case (icode)
            I_HALT, I_NOP, I_RET: begin
                need_regids = 1'b0;
            end
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
                need_regids = 1'b1;
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                need_regids = 1'b1;
                need_valC   = 1'b1;
            end
            I_JXX, I_CALL: begin
                need_valC = 1'b1;
            end
            default: begin
                instr_valid = 1'b0;
            end
        endcase
        len         = 4'd1 + {3'b000, need_regids} + (need_valC ? 4'd8 : 4'd0);
        valC_offset = need_valC ? (4'd1 + {3'b000, need_regids}) : 4'd0;
    end

endmodule

// File: rtl/y86_fetch_unit.sv
// Y86-64 fetch stage: reads up to three aligned 8-byte words around the fetch
// PC, splits out the instruction fields and hands them to decode on a
// valid/ready handshake. Also owns the predicted-PC register.
module y86_fetch_unit
    import y86_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int WORD_BYTES = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         f_pc,
    input  logic                      f_stall,
    input  logic                      f_flush,
    output logic                      imem_req,
    output logic [ADDR_W-1:0]         imem_addr,
    input  logic                      imem_ack,
    input  logic [WORD_BYTES*8-1:0]   imem_rdata,
    input  logic                      imem_err,
    output logic                      d_valid,
    input  logic                      d_ready,
    output logic [3:0]                d_icode,
    output logic [3:0]                d_ifun,
    output logic [3:0]                d_rA,
    output logic [3:0]                d_rB,
    output logic [63:0]               d_valC,
    output logic [ADDR_W-1:0]         d_valP,
    output logic [2:0]                d_stat,
    output logic [ADDR_W-1:0]         F_predPC
);

    localparam int WORD_W = WORD_BYTES * 8;
    localparam int LINE_W = 3 * WORD_W;

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic              discard;
    logic [WORD_W-1:0] word0;
    logic [WORD_W-1:0] word1;

    // Byte view of the (up to) 24 fetched bytes, including the word arriving now
    logic [LINE_W-1:0] line;
    logic [7:0]        bit_pos;
    logic [7:0]        byte0;
    logic [7:0]        byte1;
    logic [63:0]       valc_raw;
    logic [4:0]        span;
    logic              need_more;

    // Decoded fields for the instruction currently being assembled
    logic [3:0]        icode;
    logic [3:0]        len;
    logic              need_regids;
    logic              need_valC;
    logic [3:0]        valc_off;
    logic              instr_valid;
    logic [3:0]        dec_ifun;
    logic [3:0]        dec_ra;
    logic [3:0]        dec_rb;
    logic [63:0]       dec_valc;
    logic [ADDR_W-1:0] dec_valp;
    logic [2:0]        dec_stat;
    logic [ADDR_W-1:0] pred_pc;

    y86_inst_len u_inst_len (
        .icode       (icode),
        .len         (len),
        .need_regids (need_regids),
        .need_valC   (need_valC),
        .valC_offset (valc_off),
        .instr_valid (instr_valid)
    );

    // Assemble the byte line (arriving word spliced in) and extract the fields at pc[2:0]
    always_comb begin
        line = {imem_rdata,
                (state == S_WAIT1) ? imem_rdata : word1,
                (state == S_WAIT0) ? imem_rdata : word0};
        bit_pos  = {2'b00, pc[2:0], 3'b000};
        byte0    = line[bit_pos +: 8];
        byte1    = line[bit_pos + 8'd8 +: 8];
        valc_raw = line[bit_pos + {1'b0, valc_off, 3'b000} +: 64];
        icode    = byte0[7:4];
        span     = {2'b00, pc[2:0]} + {1'b0, len};

        need_more = 1'b0;
        case (state)
            S_WAIT0: need_more = (span > 5'd8);
            S_WAIT1: need_more = (span > 5'd16);
            default: need_more = 1'b0;
        endcase

        dec_ifun = instr_valid ? byte0[3:0] : 4'h0;
        dec_ra   = need_regids ? byte1[7:4] : REG_NONE;
        dec_rb   = need_regids ? byte1[3:0] : REG_NONE;
        dec_valc = need_valC ? valc_raw : 64'd0;
        dec_valp = pc + ADDR_W'(len);
        if (!instr_valid) begin
            dec_stat = STAT_INS;
        end else if (icode == I_HALT) begin
            dec_stat = STAT_HLT;
        end else begin
            dec_stat = STAT_AOK;
        end
    end

    // Next-PC prediction from the instruction held at the decode interface
    always_comb begin
        if (d_icode == I_JXX || d_icode == I_CALL) begin
            pred_pc = ADDR_W'(d_valC);
        end else begin
            pred_pc = d_valP;
        end
    end

    // Fetch controller: memory handshake, field capture, decode handshake, flush/halt
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= '0;
            discard   <= 1'b0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            d_valid   <= 1'b0;
            d_icode   <= 4'h0;
            d_ifun    <= 4'h0;
            d_rA      <= 4'h0;
            d_rB      <= 4'h0;
            d_valC    <= 64'd0;
            d_valP    <= '0;
            d_stat    <= STAT_AOK;
            F_predPC  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!f_stall) begin
                        pc        <= f_pc;
                        imem_addr <= {f_pc[ADDR_W-1:3], 3'b000};
                        imem_req  <= 1'b1;
                        discard   <= 1'b0;
                        state     <= S_WAIT0;
                    end
                end
                S_WAIT0, S_WAIT1, S_WAIT2: begin
                    if (imem_ack) begin
                        if (discard || f_flush) begin
                            // Abandoned instruction: drop it once the memory is quiet
                            imem_req <= 1'b0;
                            discard  <= 1'b0;
                            state    <= S_IDLE;
                        end else if (imem_err) begin
                            imem_req <= 1'b0;
                            d_valid  <= 1'b1;
                            d_icode  <= I_NOP;
                            d_ifun   <= 4'h0;
                            d_rA     <= REG_NONE;
                            d_rB     <= REG_NONE;
                            d_valC   <= 64'd0;
                            d_valP   <= pc;
                            d_stat   <= STAT_ADR;
                            state    <= S_OUT;
                        end else if (need_more) begin
                            imem_addr <= imem_addr + ADDR_W'(WORD_BYTES);
                            if (state == S_WAIT0) begin
                                word0 <= imem_rdata;
                                state <= S_WAIT1;
                            end else begin
                                word1 <= imem_rdata;
                                state <= S_WAIT2;
                            end
                        end else begin
                            imem_req <= 1'b0;
                            d_valid  <= 1'b1;
                            d_icode  <= icode;
                            d_ifun   <= dec_ifun;
                            d_rA     <= dec_ra;
                            d_rB     <= dec_rb;
                            d_valC   <= dec_valc;
                            d_valP   <= dec_valp;
                            d_stat   <= dec_stat;
                            state    <= S_OUT;
                        end
                    end else if (f_flush) begin
                        discard <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (f_flush) begin
                        // Flush wins over a simultaneous accept; predicted PC untouched
                        d_valid <= 1'b0;
                        state   <= S_IDLE;
                    end else if (d_ready) begin
                        d_valid  <= 1'b0;
                        F_predPC <= pred_pc;
                        state    <= (d_stat != STAT_AOK) ? S_HALTED : S_IDLE;
                    end
                end
                S_HALTED: begin
                    if (f_flush) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    imem_req <= 1'b0;
                    d_valid  <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_y86_fetch_unit.sv
// Directed bench for y86_fetch_unit: byte-addressed memory model with
// configurable ack delay, a behavioural instruction model, and a per-cycle
// compare of the decode interface while d_valid is high.
module tb_y86_fetch_unit;

    logic        clk;
    logic        rst;
    logic [63:0] f_pc;
    logic        f_stall;
    logic        f_flush;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [63:0] imem_rdata;
    logic        imem_err;
    logic        d_valid;
    logic        d_ready;
    logic [3:0]  d_icode, d_ifun, d_rA, d_rB;
    logic [63:0] d_valC, d_valP;
    logic [2:0]  d_stat;
    logic [63:0] F_predPC;

    y86_fetch_unit dut (
        .clk(clk), .rst(rst), .f_pc(f_pc), .f_stall(f_stall), .f_flush(f_flush),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .imem_err(imem_err),
        .d_valid(d_valid), .d_ready(d_ready),
        .d_icode(d_icode), .d_ifun(d_ifun), .d_rA(d_rA), .d_rB(d_rB),
        .d_valC(d_valC), .d_valP(d_valP), .d_stat(d_stat), .F_predPC(F_predPC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // ---------------- memory model ----------------
    logic [7:0]  mem [0:255];
    int          ack_delay;
    bit          err_mode;
    int          wait_cnt;
    logic [63:0] req_log [$];

    always_comb begin
        imem_rdata = '0;
        for (int k = 0; k < 8; k++) imem_rdata[8*k +: 8] = mem[imem_addr[7:0] + 8'(k)];
        imem_ack = imem_req && (wait_cnt >= ack_delay);
        imem_err = err_mode;
    end

    always @(posedge clk) begin
        if (rst || !imem_req || imem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
        if (!rst && imem_req && imem_ack) req_log.push_back(imem_addr);
    end

    task automatic put_seq(input int addr, input int n, input logic [79:0] bytes);
        for (int i = 0; i < n; i++) mem[8'(addr + i)] = bytes[8*(n-1-i) +: 8];
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        err;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp, pred;
        logic [2:0]  stat;
        logic [31:0] nwords;
    } exp_t;

    function automatic exp_t model(input logic [63:0] pc, input bit err);
        exp_t r;
        logic [7:0] b0, b1;
        logic [3:0] ic;
        int len;
        b0 = mem[pc[7:0]];
        b1 = mem[pc[7:0] + 8'd1];
        ic = b0[7:4];
        if (ic inside {4'h0, 4'h1, 4'h9}) len = 1;
        else if (ic inside {4'h2, 4'h6, 4'hA, 4'hB}) len = 2;
        else if (ic inside {4'h7, 4'h8}) len = 9;
        else if (ic inside {4'h3, 4'h4, 4'h5}) len = 10;
        else len = 1;
        r.err   = err;
        r.icode = ic;
        r.stat  = (ic == 4'h0) ? 3'd2 : (ic > 4'hB) ? 3'd4 : 3'd1;
        r.ifun  = (r.stat == 3'd4) ? 4'h0 : b0[3:0];
        r.ra    = (len == 2 || len == 10) ? b1[7:4] : 4'hF;
        r.rb    = (len == 2 || len == 10) ? b1[3:0] : 4'hF;
        r.valc  = 64'd0;
        if (len == 10) for (int i = 0; i < 8; i++) r.valc[8*i +: 8] = mem[pc[7:0] + 8'(2 + i)];
        if (len == 9)  for (int i = 0; i < 8; i++) r.valc[8*i +: 8] = mem[pc[7:0] + 8'(1 + i)];
        r.valp   = pc + 64'(len);
        r.pred   = (ic == 4'h7 || ic == 4'h8) ? r.valc : r.valp;
        r.nwords = 32'((int'(pc[2:0]) + len + 7) / 8);
        if (err) begin
            r.icode = 4'h1; r.stat = 3'd3; r.valp = pc; r.pred = pc; r.nwords = 32'd1;
        end
        return r;
    endfunction

    exp_t        ex;
    bit          exp_active;
    logic [63:0] prev_pred;

    // Compare the decode interface on every cycle it presents an instruction
    always @(negedge clk) begin
        if (!rst && d_valid) begin
            if (!exp_active) begin
                check("unexpected_d_valid", 64'd1, 64'd0);
            end else begin
                check("d_icode", 64'(d_icode), 64'(ex.icode));
                check("d_stat", 64'(d_stat), 64'(ex.stat));
                check("d_valP", d_valP, ex.valp);
                if (!ex.err) begin
                    check("d_ifun", 64'(d_ifun), 64'(ex.ifun));
                    check("d_rA", 64'(d_rA), 64'(ex.ra));
                    check("d_rB", 64'(d_rB), 64'(ex.rb));
                    check("d_valC", d_valC, ex.valc);
                end
                check("req_low_in_out", 64'(imem_req), 64'd0);
                check("predpc_hold", F_predPC, prev_pred);
            end
        end
    end

    // One full fetch: start, wait for d_valid, hold ready low, accept, verify
    task automatic run_fetch(input logic [63:0] pc, input int hold);
        int cyc;
        logic [63:0] base;
        ex = model(pc, err_mode);
        exp_active = 1'b1;
        req_log.delete();
        f_pc = pc;
        f_stall = 1'b0;
        @(negedge clk);
        f_stall = 1'b1;
        cyc = 0;
        while (!d_valid && cyc < 80) begin
            @(negedge clk);
            cyc++;
        end
        if (!d_valid) begin
            check("d_valid_timeout", 64'd0, 64'd1);
            exp_active = 1'b0;
            return;
        end
        check("latency", 64'(cyc), 64'(ex.nwords * 32'(ack_delay + 1)));
        repeat (hold) @(negedge clk);
        d_ready = 1'b1;
        @(negedge clk);
        d_ready = 1'b0;
        exp_active = 1'b0;
        check("d_valid_drop", 64'(d_valid), 64'd0);
        check("F_predPC", F_predPC, ex.pred);
        prev_pred = ex.pred;
        base = {pc[63:3], 3'b000};
        check("req_count", 64'(req_log.size()), 64'(ex.nwords));
        for (int i = 0; i < req_log.size() && i < int'(ex.nwords); i++)
            check("req_addr", req_log[i], base + 64'(8 * i));
    endtask

    task automatic pulse_flush();
        f_flush = 1'b1;
        @(negedge clk);
        f_flush = 1'b0;
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst = 1'b1; f_pc = '0; f_stall = 1'b1; f_flush = 1'b0; d_ready = 1'b0;
        ack_delay = 0; err_mode = 1'b0; exp_active = 1'b0; prev_pred = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_imem_req", 64'(imem_req), 64'd0);
        check("rst_d_valid", 64'(d_valid), 64'd0);
        check("rst_F_predPC", F_predPC, 64'd0);
        check("rst_d_stat", 64'(d_stat), 64'd1);
        check("rst_d_icode", 64'(d_icode), 64'd0);
        check("rst_d_valC", d_valC, 64'd0);
        check("rst_d_valP", d_valP, 64'd0);

        // irmovq at pc 0: two words
        put_seq(0, 10, 80'h30F48877665544332211);
        ex = model(64'h0, 1'b0);
        check("model_irmovq_valC", ex.valc, 64'h1122334455667788);
        check("model_irmovq_valP", ex.valp, 64'hA);
        check("model_irmovq_rB", 64'(ex.rb), 64'h4);
        check("model_irmovq_words", 64'(ex.nwords), 64'd2);
        run_fetch(64'h0, 0);
        check("irmovq_predPC_lit", F_predPC, 64'hA);

        // Same instruction at pc 7: three words, immediate and delayed acks
        put_seq(7, 10, 80'h30F48877665544332211);
        ex = model(64'h7, 1'b0);
        check("model_off7_valP", ex.valp, 64'h11);
        run_fetch(64'h7, 0);
        check("off7_third_req", (req_log.size() > 2) ? req_log[2] : '1, 64'h10);
        ack_delay = 2;
        run_fetch(64'h7, 1);
        ack_delay = 0;

        // jXX at 0x20, decode held off for 5 cycles
        put_seq(32, 9, 80'h700001000000000000);
        ex = model(64'h20, 1'b0);
        check("model_jxx_valC", ex.valc, 64'h100);
        check("model_jxx_valP", ex.valp, 64'h29);
        run_fetch(64'h20, 5);
        check("jxx_predPC_lit", F_predPC, 64'h100);

        // Flush while waiting on the second word of a three-word fetch
        put_seq(8'h47, 10, 80'h30F48877665544332211);
        ack_delay = 3;
        req_log.delete();
        exp_active = 1'b0;
        f_pc = 64'h47;
        f_stall = 1'b0;
        @(negedge clk);
        f_stall = 1'b1;
        cyc = 0;
        while (req_log.size() < 1 && cyc < 40) begin @(negedge clk); cyc++; end
        check("flush_first_word_seen", 64'(req_log.size()), 64'd1);
        check("flush_wait1_addr", imem_addr, 64'h48);
        check("flush_wait1_req", 64'(imem_req), 64'd1);
        pulse_flush();
        cyc = 0;
        while (imem_req && cyc < 40) begin @(negedge clk); cyc++; end
        check("flush_req_released", 64'(imem_req), 64'd0);
        repeat (3) @(negedge clk);
        check("flush_req_count", 64'(req_log.size()), 64'd2);
        check("flush_predPC_same", F_predPC, prev_pred);
        ack_delay = 0;
        put_seq(8'h60, 1, 80'h10);
        run_fetch(64'h60, 0);

        // Address error on word0, then halted until flush
        put_seq(8'h80, 1, 80'h10);
        err_mode = 1'b1;
        run_fetch(64'h80, 0);
        err_mode = 1'b0;
        f_stall = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("halted_no_req", 64'(imem_req), 64'd0);
            check("halted_no_valid", 64'(d_valid), 64'd0);
        end
        f_stall = 1'b1;
        pulse_flush();
        run_fetch(64'h60, 0);

        // Invalid instruction byte
        put_seq(8'h90, 1, 80'hC0);
        ex = model(64'h90, 1'b0);
        check("model_ins_stat", 64'(ex.stat), 64'd4);
        check("model_ins_valP", ex.valp, 64'h91);
        run_fetch(64'h90, 0);
        pulse_flush();

        // halt: HLT status, then halted
        put_seq(8'hA0, 1, 80'h00);
        run_fetch(64'hA0, 2);
        f_stall = 1'b0;
        repeat (4) @(negedge clk);
        check("hlt_no_req", 64'(imem_req), 64'd0);
        f_stall = 1'b1;
        pulse_flush();

        // Flush in OUT beats a simultaneous d_ready
        ex = model(64'h60, 1'b0);
        exp_active = 1'b1;
        f_pc = 64'h60;
        f_stall = 1'b0;
        @(negedge clk);
        f_stall = 1'b1;
        cyc = 0;
        while (!d_valid && cyc < 40) begin @(negedge clk); cyc++; end
        check("out_flush_valid_seen", 64'(d_valid), 64'd1);
        f_flush = 1'b1;
        d_ready = 1'b1;
        @(negedge clk);
        f_flush = 1'b0;
        d_ready = 1'b0;
        exp_active = 1'b0;
        check("out_flush_valid_drop", 64'(d_valid), 64'd0);
        check("out_flush_predPC_same", F_predPC, prev_pred);
        repeat (3) @(negedge clk);
        check("out_flush_idle_no_req", 64'(imem_req), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
